// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the digit scan controller.
package scan_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned IDX_W    = $clog2(DIGITS);

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StBlank
  } state_e;

  // Counter must hold the larger of the two phase lengths.
  function automatic int unsigned timer_w(input int unsigned dwell, input int unsigned blank);
    int unsigned m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with terminal-count flag, shared by dwell and blank phases.
module scan_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit scan controller driving a 2:4 decoder with dwell/blank timing and framed loads.
// Optional leading-zero blanking is enabled by defining SCAN_ZERO_SUPPRESS_EN.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [WORD_W-1:0]   data_in,
  input  logic                load,
  output logic                ready,
  input  logic [DIGITS-1:0]   digit_mask,
  output logic                a,
  output logic                b,
  output logic                en,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                frame_done
);

  localparam int unsigned TW = timer_w(DWELL, BLANK);
  localparam logic [TW-1:0] DwellLd = TW'(DWELL - 1);
  localparam logic [TW-1:0] BlankLd = TW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d, shadow_q, shadow_d;
  logic                pend_q, pend_d;
  logic                en_q, en_d;
  logic [NIBBLE_W-1:0] nib_q, nib_d;
  logic                fd_q, fd_d;
  logic                ready_q;
  logic                enter_on, boundary, accept, suppress;
  logic                tmr_load, tmr_tc;
  logic [TW-1:0]       tmr_val;

  scan_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    enter_on = 1'b0;
    fd_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = DwellLd;
    if (!run) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StOn;
          idx_d    = '0;
          enter_on = 1'b1;
        end
        StOn: begin
          if (tmr_tc) begin
            if (BLANK == 0) begin
              idx_d    = idx_q + 1'b1;
              enter_on = 1'b1;
              fd_d     = (idx_q == LastIdx);
            end else begin
              state_d  = StBlank;
              tmr_load = 1'b1;
              tmr_val  = BlankLd;
            end
          end
        end
        StBlank: begin
          if (tmr_tc) begin
            state_d  = StOn;
            idx_d    = idx_q + 1'b1;
            enter_on = 1'b1;
            fd_d     = (idx_q == LastIdx);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (enter_on) begin
      tmr_load = 1'b1;
      tmr_val  = DwellLd;
    end
  end

  // The active word may only change where a new frame starts or while idle.
  assign boundary = enter_on && (idx_d == '0);
  assign accept   = load && ready_q;

  always_comb begin
    word_d   = word_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (boundary || (state_q == StIdle)) begin
      if (accept) begin
        word_d = data_in;
      end else if (pend_q) begin
        word_d = shadow_q;
        pend_d = 1'b0;
      end
    end else if (accept) begin
      shadow_d = data_in;
      pend_d   = 1'b1;
    end
  end

`ifdef SCAN_ZERO_SUPPRESS_EN
  // Blank a digit when it and every more-significant nibble are zero; digit 0 always shows.
  assign suppress = (idx_d != '0) && ((word_d >> (NIBBLE_W * idx_d)) == '0);
`else
  assign suppress = 1'b0;
`endif

  assign en_d  = (state_d == StOn) && digit_mask[idx_d] && !suppress;
  assign nib_d = enter_on ? word_d[NIBBLE_W*idx_d +: NIBBLE_W] : nib_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      word_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      nib_q    <= '0;
      fd_q     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      nib_q    <= nib_d;
      fd_q     <= fd_d;
      ready_q  <= !pend_d;
    end
  end

  assign a          = idx_q[0];
  assign b          = idx_q[1];
  assign en         = en_q;
  assign nibble     = nib_q;
  assign ready      = ready_q;
  assign frame_done = fd_q;

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

- Time-multiplexed scan controller that sits directly upstream of `decoder_2_4`.
- Drives the decoder's select inputs `a`/`b` and its enable `en` so that one of four digit lines is active at a time.
- Presents the matching 4-bit nibble of a 16-bit display word for the downstream segment logic.
- Provides dwell/blanking timing, per-digit masking and a load handshake that updates the word only at frame boundaries.

## Interface
Parameters:
- `DWELL`, 1000: cycles `en` may be high per digit slot; legal range ≥1.
- `BLANK`, 16: cycles `en` is forced low after each slot (anti-ghosting); legal range ≥0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  scanning enabled while high.
- `data_in`  in  16  display word; digit i = `data_in[4i+3:4i]`.
- `load`  in  1  write strobe, accepted when `load & ready`.
- `ready`  out  1  high = shadow register free.
- `digit_mask`  in  4  bit i = 1 enables digit i; sampled live.
- `a`  out  1  select LSB to decoder (index bit 0).
- `b`  out  1  select MSB to decoder (index bit 1).
- `en`  out  1  decoder enable.
- `nibble`  out  4  nibble of currently selected digit.
- `frame_done`  out  1  one-cycle pulse per completed frame.

## Operation
- All outputs are registered.
- Reset values: `a=b=0`, `en=0`, `nibble=0`, `ready=1`, `frame_done=0`; active word, shadow and pending flag are cleared; state is IDLE; index is 0.
- The reset takes effect asynchronously at any point, including mid-slot or mid-handshake.
- States:
  - IDLE: `en=0`, index 0.
  - ON: `en=digit_mask[idx]` (gated further by the macro), held for DWELL cycles.
  - BLANK: `en=0` for BLANK cycles. `a`, `b` and `nibble` hold their values.
- Transitions:
  - IDLE→ON(idx 0) at the first edge with `run=1`.
  - ON→BLANK after DWELL cycles. If BLANK=0, ON→ON(idx+1) directly.
  - BLANK→ON(idx+1) after BLANK cycles.
  - The index wraps 3→0.
- `run=0` in any state: at the next edge go to IDLE, set `en=0` and index 0. `frame_done` is not pulsed.
- Frame boundary: any edge that enters ON with idx 0 (including IDLE→ON and the 3→0 wrap).
- Load handshake:
  - `load & ready` at an edge latches `data_in` into the shadow register, sets pending, and drops `ready` at that edge.
  - On the next frame boundary, or the next edge while in IDLE, the shadow is copied to the active word, pending clears and `ready` rises.
  - If `load & ready` coincides with a frame boundary or an IDLE edge, `data_in` is written straight to the active word and `ready` stays high.
  - `load` while `ready=0` is ignored; no data is lost from the shadow.
- `nibble` is taken from the active word for the index entering ON. The active word never changes mid-frame.
- `frame_done` pulses high for one cycle, coincident with the 3→0 wrap into ON.

## Timing
- `en` rises one cycle after `run` is first sampled high.
- `a`, `b`, `nibble` and `en` change on the same edge. Select and data are never skewed against the enable.
- Each slot is DWELL cycles with `en` possibly high, followed by BLANK cycles low. Frame period = 4·(DWELL+BLANK) cycles.
- Masked digits still consume their full slot, so duty cycle stays constant.
- Load-to-display latency is at most one frame period plus one cycle.
- The timer counter width is $clog2(max(DWELL,BLANK)+1).

## Configuration
- `SCAN_ZERO_SUPPRESS_EN`, when defined:
  - Leading-zero digits are blanked: digit i (i=3..1) has `en=0` if its nibble and all higher nibbles of the active word are 0.
  - Digit 0 is never suppressed.
  - Suppression is ANDed with `digit_mask`.
- Without the macro, `en` in ON equals `digit_mask[idx]` only.

## Structure
- Shared package `scan_pkg`: state enum (IDLE, ON, BLANK), `DIGITS=4`, `NIBBLE_W=4`, `WORD_W=16`, and a width-calc function for the timer.
- One sub-module, `scan_timer`: a loadable down-counter with a terminal-count output, reused for both the dwell and blank phases.

## Test plan
All scenarios use DWELL=4, BLANK=2.
- Reset mid-slot with `rst_n` low: all outputs at reset values immediately. Release with `run=1`: `en` rises 1 cycle later, `a=b=0`.
- `run=1`, `digit_mask=4'hF`, word 16'h4321:
  - `en` high 4 cycles and low 2 cycles per slot.
  - `(b,a)` steps 00,01,10,11 with nibble 1,2,3,4.
  - `frame_done` pulses every 24 cycles.
- `digit_mask=4'b0101`: `en` high only in slots 0 and 2; slot timing is unchanged.
- `load` 16'hABCD in mid-frame: `ready` goes low the next cycle; the old word finishes the frame; the new nibbles appear from the next wrap, with `ready` high at the same edge.
- `run` dropped during BLANK of slot 1: IDLE next edge, `en=0`, no `frame_done`. Rerun: restarts at idx 0.
- With `SCAN_ZERO_SUPPRESS_EN` and word 16'h0070: `en` is low for slots 3 and 2, high for slots 1 and 0. Without the macro, all four slots are high.
